mult_div_unit: RTL and testbench

- Iterative 32-bit multiply/divide unit for the execute stage of the MIPS datapath. It sits beside the ALU and takes the same A/B operands from the register-read stage.
- It executes MULT, MULTU, DIV and DIVU into the architectural HI/LO registers.
- HI/LO feed the ALUResult write-back mux for MFHI/MFLO.
- Busy drives the hazard unit, which stalls any MFHI/MFLO or new mult/div until Done.

---
 rtl/mult_div_unit.sv | 216 +++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : Iterative WIDTH-bit multiply/divide unit (MULT, MULTU, DIV,
//                DIVU) writing the architectural HI/LO registers. One result
//                bit per cycle: shift-add multiply, restoring divide, then a
//                single sign-fix cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             MTHI,
    input  logic             MTLO,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 is_div_q, is_div_d;     // latched Op[1]
    logic                 neg_q, neg_d;           // product / quotient sign
    logic                 rem_neg_q, rem_neg_d;   // remainder follows dividend
    logic                 bzero_q, bzero_d;       // divisor was zero
    logic [WIDTH-1:0]     a_orig_q, a_orig_d;     // raw A for divide-by-zero HI
    logic [WIDTH-1:0]     mcand_q, mcand_d;       // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   acc_q, acc_d;           // product accumulator / dividend-quotient shifter
    logic [WIDTH:0]       rem_q, rem_d;           // partial remainder
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 dbz_q, dbz_d;

    // Operand sign/magnitude split; signed only when Op[0] is set
    logic                 w_a_neg, w_b_neg;
    logic [WIDTH-1:0]     w_a_mag, w_b_mag;

    assign w_a_neg = Op[0] & A[WIDTH-1];
    assign w_b_neg = Op[0] & B[WIDTH-1];
    assign w_a_mag = w_a_neg ? -A : A;
    assign w_b_mag = w_b_neg ? -B : B;

    // One shift-add step: add multiplicand into the upper half when the
    // current multiplier bit (acc LSB) is set, then shift right with carry.
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;

    assign w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign w_mul_next = {w_mul_sum, acc_q[WIDTH-1:1]};

    // One restoring divide step: bring in the next dividend bit, trial
    // subtract the divisor and keep the difference only if it did not borrow.
    logic [WIDTH+1:0]     w_shift;
    logic [WIDTH+1:0]     w_diff;
    logic                 w_qbit;
    logic [WIDTH:0]       w_rem_next;
    logic [2*WIDTH-1:0]   w_div_next;

    assign w_shift    = {rem_q, acc_q[WIDTH-1]};
    assign w_diff     = w_shift - {2'b00, mcand_q};
    assign w_qbit     = ~w_diff[WIDTH+1];
    assign w_rem_next = w_qbit ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
    assign w_div_next = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], w_qbit};

    // Sign correction applied in the FIX cycle
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;

    assign w_prod = neg_q     ? -acc_q              : acc_q;
    assign w_quo  = neg_q     ? -acc_q[WIDTH-1:0]   : acc_q[WIDTH-1:0];
    assign w_rem  = rem_neg_q ? -rem_q[WIDTH-1:0]   : rem_q[WIDTH-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: IDLE -> CALC for WIDTH cycles -> FIX -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (Start)          state_d = S_CALC;
            S_CALC:  if (cnt_q == c_LAST) state_d = S_FIX;
            S_FIX:                        state_d = S_IDLE;
            default:                      state_d = S_IDLE;
        endcase
    end

    // Datapath next values: operand capture, iteration step, result write-back
    always_comb begin
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        bzero_d   = bzero_q;
        a_orig_d  = a_orig_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    // Start wins over MTHI/MTLO in the same cycle
                    is_div_d  = Op[1];
                    neg_d     = w_a_neg ^ w_b_neg;
                    rem_neg_d = w_a_neg;
                    bzero_d   = (B == '0);
                    a_orig_d  = A;
                    mcand_d   = Op[1] ? w_b_mag : w_a_mag;
                    acc_d     = Op[1] ? {{WIDTH{1'b0}}, w_a_mag} : {{WIDTH{1'b0}}, w_b_mag};
                    rem_d     = '0;
                    cnt_d     = '0;
                    dbz_d     = 1'b0;
                end else begin
                    if (MTHI) hi_d = A;
                    if (MTLO) lo_d = A;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + c_CNT_W'(1);
                if (is_div_q) begin
                    acc_d = w_div_next;
                    rem_d = w_rem_next;
                end else begin
                    acc_d = w_mul_next;
                end
            end
            S_FIX: begin
                done_d = 1'b1;
                if (is_div_q && bzero_q) begin
                    hi_d  = a_orig_q;
                    lo_d  = '1;
                    dbz_d = 1'b1;
                end else if (is_div_q) begin
                    hi_d = w_rem;
                    lo_d = w_quo;
                end else begin
                    hi_d = w_prod[2*WIDTH-1:WIDTH];
                    lo_d = w_prod[WIDTH-1:0];
                end
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // Datapath and architectural registers; reset also aborts any operation
    always_ff @(posedge clk) begin
        if (reset) begin
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            bzero_q   <= 1'b0;
            a_orig_q  <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            bzero_q   <= bzero_d;
            a_orig_q  <= a_orig_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign Busy      = (state_q != S_IDLE);
    assign Done      = done_q;
    assign DivByZero = dbz_q;
    assign HI        = hi_q;
    assign LO        = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div_unit
//  Description : Self-checking bench for mult_div_unit. Directed cases plus
//                randomized operations compared against an arithmetic model
//                of HI/LO/DivByZero built from 64-bit integer math.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             MTHI;
    logic             MTLO;
    logic             Busy;
    logic             Done;
    logic             DivByZero;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    int               n_checks = 0;
    int               n_fail   = 0;

    // Reference architectural state
    logic [31:0]      m_hi = '0;
    logic [31:0]      m_lo = '0;
    logic             m_dbz = 1'b0;

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (Start),
        .Op        (Op),
        .A         (A),
        .B         (B),
        .MTHI      (MTHI),
        .MTLO      (MTLO),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero),
        .HI        (HI),
        .LO        (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural result of one operation, from plain integer arithmetic
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa, sb, q, r;
        if (!op[1]) begin
            if (op[0]) p = longint'($signed(a)) * longint'($signed(b));
            else       p = {32'd0, a} * {32'd0, b};
            m_hi  = p[63:32];
            m_lo  = p[31:0];
            m_dbz = 1'b0;
        end else if (b == 32'd0) begin
            m_hi  = a;
            m_lo  = 32'hFFFF_FFFF;
            m_dbz = 1'b1;
        end else if (op[0]) begin
            sa    = longint'($signed(a));
            sb    = longint'($signed(b));
            q     = sa / sb;
            r     = sa % sb;
            m_lo  = q[31:0];
            m_hi  = r[31:0];
            m_dbz = 1'b0;
        end else begin
            m_lo  = a / b;
            m_hi  = a % b;
            m_dbz = 1'b0;
        end
    endtask

    // Idle MTHI/MTLO write, checked on the following cycle
    task automatic mt_write(input logic hi_en, input logic lo_en, input logic [31:0] val);
        MTHI = hi_en;
        MTLO = lo_en;
        A    = val;
        tick();
        MTHI = 1'b0;
        MTLO = 1'b0;
        if (hi_en) m_hi = val;
        if (lo_en) m_lo = val;
        check("mt_hi", HI, m_hi);
        check("mt_lo", LO, m_lo);
    endtask

    // Launch one operation and check timing, hold behaviour and result
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic with_mt);
        logic [31:0] old_hi, old_lo;
        int          done_cyc;
        int          busy_bad;
        old_hi   = m_hi;
        old_lo   = m_lo;
        done_cyc = 0;
        busy_bad = 0;
        Op    = op;
        A     = a;
        B     = b;
        Start = 1'b1;
        MTHI  = with_mt;
        MTLO  = with_mt;
        tick();
        Start = 1'b0;
        MTHI  = 1'b0;
        MTLO  = 1'b0;
        A     = $urandom;
        B     = $urandom;
        model(op, a, b);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc == 1) begin
                check($sformatf("dbz_clear op%0d", op), {63'd0, DivByZero}, 64'd0);
                check($sformatf("hi_hold op%0d", op), HI, old_hi);
                check($sformatf("lo_hold op%0d", op), LO, old_lo);
            end
            if (Done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            if (Busy !== 1'b1) busy_bad++;
            tick();
        end
        check($sformatf("latency op%0d", op), done_cyc, 64'd34);
        check($sformatf("busy_window op%0d", op), busy_bad, 64'd0);
        check($sformatf("busy_at_done op%0d", op), {63'd0, Busy}, 64'd0);
        check($sformatf("hi op%0d a=%h b=%h", op, a, b), HI, m_hi);
        check($sformatf("lo op%0d a=%h b=%h", op, a, b), LO, m_lo);
        check($sformatf("dbz op%0d", op), {63'd0, DivByZero}, {63'd0, m_dbz});
        tick();
        check($sformatf("done_pulse op%0d", op), {63'd0, Done}, 64'd0);
    endtask

    initial begin
        int          seen_done;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        reset = 1'b1;
        Start = 1'b0;
        Op    = 2'b00;
        A     = '0;
        B     = '0;
        MTHI  = 1'b0;
        MTLO  = 1'b0;
        tick();
        tick();
        check("rst_busy", {63'd0, Busy}, 64'd0);
        check("rst_done", {63'd0, Done}, 64'd0);
        check("rst_dbz",  {63'd0, DivByZero}, 64'd0);
        check("rst_hi",   HI, 64'd0);
        check("rst_lo",   LO, 64'd0);
        reset = 1'b0;
        tick();

        // Directed results
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_max_hi", HI, 64'hFFFF_FFFE);
        check("multu_max_lo", LO, 64'h0000_0001);
        run_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
        run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        run_op(2'b10, 32'd100, 32'd7, 1'b0);
        run_op(2'b10, 32'd100, 32'd0, 1'b0);
        check("divu0_dbz", {63'd0, DivByZero}, 64'd1);
        run_op(2'b00, 32'd6, 32'd9, 1'b0);

        // Inputs ignored while busy, then reset aborts the operation
        mt_write(1'b1, 1'b0, 32'h1111_1111);
        seen_done = 0;
        Op    = 2'b00;
        A     = 32'd3;
        B     = 32'd5;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 1; i < 5; i++) begin
            if (Done === 1'b1) seen_done++;
            tick();
        end
        Start = 1'b1;
        Op    = 2'b11;
        MTHI  = 1'b1;
        A     = 32'hDEAD_BEEF;
        tick();
        Start = 1'b0;
        MTHI  = 1'b0;
        check("busy_ignore_hi", HI, 64'h1111_1111);
        check("busy_still", {63'd0, Busy}, 64'd1);
        for (int i = 6; i < 10; i++) begin
            if (Done === 1'b1) seen_done++;
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi  = '0;
        m_lo  = '0;
        m_dbz = 1'b0;
        check("abort_busy", {63'd0, Busy}, 64'd0);
        check("abort_hi", HI, 64'd0);
        check("abort_lo", LO, 64'd0);
        for (int i = 0; i < 40; i++) begin
            if (Done === 1'b1) seen_done++;
            tick();
        end
        check("abort_no_done", seen_done, 64'd0);

        // Idle moves, DIV overflow, Start with MTLO
        mt_write(1'b1, 1'b0, 32'h1234_5678);
        mt_write(1'b1, 1'b1, 32'hCAFE_F00D);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf_lo", LO, 64'h8000_0000);
        check("div_ovf_hi", HI, 64'h0);
        mt_write(1'b0, 1'b1, 32'h5555_5555);
        run_op(2'b01, 32'h0000_0010, 32'hFFFF_FFF0, 1'b1);

        // Randomized operations with occasional idle moves
        for (int n = 0; n < 24; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 3) == 0) mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            run_op(rop, ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
